// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: sequencer states and the
// default operand width also used by the combinational adder.
package arith_pkg;

  localparam int ARITH_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The ovf signal exists only when SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = ARITH_DATA_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] diff;
  logic                  bout;
`ifdef SUB_OVERFLOW_EN
  logic                  ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif

endinterface

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per clock, LSB first.
// Define SUB_OVERFLOW_EN to add the signed overflow flag.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter  int DATA_WIDTH = ARITH_DATA_WIDTH,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSB);

  sub_state_t state;
  sub_state_t state_nxt;

  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] diff_q;
  logic [CNT_W-1:0]      cnt;
  logic                  brw;
  logic                  bout_q;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic brw_nxt;
  logic last;
  logic accept;
  logic run;

  assign a_bit  = a_q[cnt];
  assign b_bit  = b_q[cnt];
  assign last   = (cnt == CNT_LAST);
  assign run    = (state == ST_RUN);
  assign accept = (state == ST_IDLE) & bus.in_valid;

  full_subtractor u_cell (
    .a    (a_bit),
    .b    (b_bit),
    .bin  (brw),
    .d    (d_bit),
    .bout (brw_nxt)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last)          state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // diff is built in place; it is only meaningful once in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
      brw <= bus.bin;
      cnt <= '0;
    end else if (run) begin
      diff_q[cnt] <= d_bit;
      brw         <= brw_nxt;
      cnt         <= last ? '0 : cnt + CNT_W'(1);
      if (last) bout_q <= brw_nxt;
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic ovf_q;

  // on the last bit d_bit is the result MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (run && last) begin
      ovf_q <= (a_q[MSB] ^ b_q[MSB]) & (a_q[MSB] ^ d_bit);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

endmodule
